seg_scan_disp: RTL and testbench

Display back-end for the ultrasonic ranging path. It sits directly downstream of the echo-timing counter and consumes that counter's four BCD distance digits and its `trig` output. On each rising edge of `trig` it snapshots the finished measurement, before the counter clears. It then drives a 4-digit common-anode multiplexed 7-segment display with anti-ghosting blanking, optional leading-zero suppression and an error pattern for invalid BCD.

---
 rtl/seg_scan_disp_if.sv | 21 ++
 rtl/seg_scan_disp.sv | 110 +++++++++++
 tb/tb_seg_scan_disp.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/seg_scan_disp_if.sv
// Pin bundle between the echo-timing counter, the display back-end and the LED driver pins.
interface seg_scan_disp_if;
  logic       trig;
  logic [3:0] count_one;
  logic [3:0] count_ten;
  logic [3:0] count_hundred;
  logic [3:0] count_thousand;
  logic [7:0] seg;
  logic [3:0] dig;
  logic       new_sample;

  modport master (
    output trig, count_one, count_ten, count_hundred, count_thousand,
    input  seg, dig, new_sample
  );

  modport slave (
    input  trig, count_one, count_ten, count_hundred, count_thousand,
    output seg, dig, new_sample
  );
endinterface

// File: rtl/seg_scan_disp.sv
// 4-digit multiplexed common-anode 7-segment back-end: snapshots BCD on trig rise, 2 cycles to pins.
// Optional leading-zero suppression under LEADING_ZERO_BLANK_EN; invalid BCD shows dashes.
module seg_scan_disp #(
  parameter int SCAN_DIV  = 27000,
  parameter int BLANK_CYC = 270
) (
  input  logic           clk,
  input  logic           rstn,
  seg_scan_disp_if.slave bus
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} slot_t;

  slot_t           state, state_nxt;
  logic [CW-1:0]   scnt;
  logic [1:0]      idx;
  logic            trig_d;
  logic            capture;
  logic            wrap;
  logic            bad_bcd;
  logic            err;
  logic            new_sample;
  logic            lz_blank;
  logic [3:0][3:0] disp;
  logic [3:0]      cur;
  logic [3:0]      dig, dig_nxt;
  logic [7:0]      seg, seg_nxt;

  function automatic logic [7:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 8'hC0;
      4'd1:    decode = 8'hF9;
      4'd2:    decode = 8'hA4;
      4'd3:    decode = 8'hB0;
      4'd4:    decode = 8'h99;
      4'd5:    decode = 8'h92;
      4'd6:    decode = 8'h82;
      4'd7:    decode = 8'hF8;
      4'd8:    decode = 8'h80;
      4'd9:    decode = 8'h90;
      default: decode = 8'hFF;
    endcase
  endfunction

  assign capture = bus.trig & ~trig_d;
  assign wrap    = (scnt == CW'(SCAN_DIV - 1));
  assign bad_bcd = (bus.count_one > 4'd9) | (bus.count_ten > 4'd9) |
                   (bus.count_hundred > 4'd9) | (bus.count_thousand > 4'd9);

  assign bus.seg        = seg;
  assign bus.dig        = dig;
  assign bus.new_sample = new_sample;

  // Follows trig even while in reset, so a trig already high at release is not an edge.
  always_ff @(posedge clk) trig_d <= bus.trig;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      scnt       <= '0;
      idx        <= 2'd0;
      state      <= BLANK;
      disp       <= '0;
      err        <= 1'b0;
      new_sample <= 1'b0;
      seg        <= 8'hFF;
      dig        <= 4'hF;
    end else begin
      scnt       <= wrap ? '0 : scnt + CW'(1);
      if (wrap) idx <= idx + 2'd1;
      state      <= state_nxt;
      new_sample <= capture;
      if (capture) begin
        disp <= {bus.count_thousand, bus.count_hundred, bus.count_ten, bus.count_one};
        err  <= bad_bcd;
      end
      seg        <= seg_nxt;
      dig        <= dig_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    seg_nxt   = 8'hFF;
    dig_nxt   = 4'hF;
    lz_blank  = 1'b0;
    cur       = disp[idx];
`ifdef LEADING_ZERO_BLANK_EN
    case (idx)
      2'd3:    lz_blank = (disp[3] == 4'd0);
      2'd2:    lz_blank = (disp[3] == 4'd0) && (disp[2] == 4'd0);
      2'd1:    lz_blank = (disp[3] == 4'd0) && (disp[2] == 4'd0) && (disp[1] == 4'd0);
      default: lz_blank = 1'b0;
    endcase
`endif
    case (state)
      BLANK: begin
        if (scnt == CW'(BLANK_CYC - 1)) state_nxt = DRIVE;
      end
      DRIVE: begin
        if (wrap) state_nxt = BLANK;
        dig_nxt = ~(4'b0001 << idx);
        if (err)           seg_nxt = 8'hBF;
        else if (lz_blank) seg_nxt = 8'hFF;
        else               seg_nxt = decode(cur);
      end
      default: state_nxt = BLANK;
    endcase
  end
endmodule

// File: tb/tb_seg_scan_disp.sv
// Bench for seg_scan_disp: directed scenarios plus random captures against a cycle-count model.
module tb_seg_scan_disp;
  localparam int SD = 20;
  localparam int BC = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  seg_scan_disp_if bus();

  seg_scan_disp #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: n = active edges since the last reset edge.
  int         n = 0;
  logic [3:0] m_disp [4];
  logic       m_err   = 1'b0;
  logic       m_ptrig = 1'b0;
  logic [7:0] exp_seg;
  logic [3:0] exp_dig;
  logic       exp_ns;
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (n=%0d)", tag, got, expv, n);
    end
  endtask

  function automatic logic [7:0] exp_code(input int slot);
    int lead;
    if (m_err) return 8'hBF;
    lead = 0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int d = 3; d >= 1; d--) begin
      if (m_disp[d] != 4'd0) break;
      lead++;
    end
`endif
    if (slot >= 4 - lead) return 8'hFF;
    if (m_disp[slot] > 4'd9) return 8'hBF;
    return seg_tab[m_disp[slot]];
  endfunction

  task automatic tick();
    int pos;
    int slot;
    @(posedge clk);
    if (!rstn) begin
      exp_seg = 8'hFF;
      exp_dig = 4'hF;
      exp_ns  = 1'b0;
      n       = 0;
      m_err   = 1'b0;
      for (int i = 0; i < 4; i++) m_disp[i] = 4'd0;
    end else begin
      pos  = n % SD;
      slot = (n / SD) % 4;
      if (pos < BC) begin
        exp_seg = 8'hFF;
        exp_dig = 4'hF;
      end else begin
        exp_dig = ~(4'b0001 << slot);
        exp_seg = exp_code(slot);
      end
      exp_ns = bus.trig && !m_ptrig;
      if (exp_ns) begin
        m_disp[0] = bus.count_one;
        m_disp[1] = bus.count_ten;
        m_disp[2] = bus.count_hundred;
        m_disp[3] = bus.count_thousand;
        m_err = (bus.count_one > 9) || (bus.count_ten > 9) ||
                (bus.count_hundred > 9) || (bus.count_thousand > 9);
      end
      n++;
    end
    m_ptrig = bus.trig;
    #1;
    chk("seg", 32'(bus.seg), 32'(exp_seg));
    chk("dig", 32'(bus.dig), 32'(exp_dig));
    chk("new_sample", 32'(bus.new_sample), 32'(exp_ns));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic set_digits(input logic [3:0] th, input logic [3:0] hu,
                            input logic [3:0] te, input logic [3:0] on);
    bus.count_thousand = th;
    bus.count_hundred  = hu;
    bus.count_ten      = te;
    bus.count_one      = on;
  endtask

  // Raise trig with the given digits; upstream clears its count right after the edge.
  task automatic capture(input logic [3:0] th, input logic [3:0] hu,
                         input logic [3:0] te, input logic [3:0] on, input int hold);
    set_digits(th, hu, te, on);
    bus.trig = 1'b1;
    tick();
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    run(hold - 1);
    bus.trig = 1'b0;
  endtask

  initial begin
    bus.trig = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);

    rstn = 1'b0;
    run(5);
    rstn = 1'b1;
    run(BC + 3);
    run(4 * SD);

    capture(4'd1, 4'd2, 4'd3, 4'd4, 27);
    run(4 * SD + 5);

    capture(4'd0, 4'd0, 4'd4, 4'd2, 3);
    run(4 * SD);

    capture(4'd10, 4'd0, 4'd0, 4'd0, 2);
    run(4 * SD);
    capture(4'd0, 4'd1, 4'd0, 4'd0, 2);
    run(4 * SD);

    // trig already high when reset releases: no capture
    bus.trig = 1'b1;
    set_digits(4'd9, 4'd8, 4'd7, 4'd6);
    rstn = 1'b0;
    run(3);
    rstn = 1'b1;
    run(10);
    bus.trig = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    run(5);

    // one-cycle reset in the middle of the hundreds slot
    capture(4'd5, 4'd6, 4'd7, 4'd8, 1);
    for (int i = 0; i < 8 * SD; i++) begin
      if (((n / SD) % 4) == 2 && (n % SD) == SD / 2) break;
      tick();
    end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    run(4 * SD + 2);

    for (int k = 0; k < 40; k++) begin
      logic [3:0] th;
      th = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      capture(th, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
              4'($urandom_range(0, 9)), int'($urandom_range(1, 8)));
      set_digits(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
      end
      run(int'($urandom_range(1, 3 * SD)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
